// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_MAX_W = 128;

  // Low `width` bits set; callers cast down to their operand width.
  function automatic logic [DIV_MAX_W-1:0] DIV_BY_ZERO_QUOT(input int width);
    logic [DIV_MAX_W-1:0] ones;
    ones = '1;
    return ones >> (DIV_MAX_W - width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted  = {rem, quo[WIDTH-1]};
  // rem < dvs on entry, so a non-negative trial always fits back in WIDTH bits.
  assign trial    = shifted - {1'b0, dvs};
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring DIV/REM unit with start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN to honour is_signed (two's-complement operands).
//
// state | meaning
// IDLE  | waiting for start, results held
// CALC  | one restoring step per cycle, counter counts down from WIDTH
// DONE  | one-cycle done pulse, new start accepted
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] DZ_QUOT = WIDTH'(DIV_BY_ZERO_QUOT(WIDTH));

  div_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] rem_d, rem_q, quo_d, quo_q, dvs_d, dvs_q;
  logic [WIDTH-1:0] quotient_d, quotient_q, remainder_d, remainder_q;
  logic             dbz_d, dbz_q;

  logic             accept;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix;

  assign accept = start && (state_q != CALC);

`ifdef SEQ_DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_quo_d, neg_quo_q, neg_rem_d, neg_rem_q;

  assign a_neg        = is_signed & dividend[WIDTH-1];
  assign b_neg        = is_signed & divisor[WIDTH-1];
  assign dividend_mag = a_neg ? -dividend : dividend;
  assign divisor_mag  = b_neg ? -divisor : divisor;
  assign quo_fix      = neg_quo_q ? -step_quo : step_quo;
  assign rem_fix      = neg_rem_q ? -step_rem : step_rem;

  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dividend_mag     = dividend;
  assign divisor_mag      = divisor;
  assign quo_fix          = step_quo;
  assign rem_fix          = step_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (divisor == '0) begin
            // Zero divisor skips iteration; remainder is the raw dividend.
            state_d     = DONE;
            quotient_d  = DZ_QUOT;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_W'(WIDTH);
            rem_d   = '0;
            quo_d   = dividend_mag;
            dvs_d   = divisor_mag;
            dbz_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule
